// File: rtl/vending_controller.sv
// Vending machine sequencer: owns the money total, inactivity timer and
// IDLE/ACTIVE/RETURN state machine; pays change greedily one coin per cycle.
//
// state    | meaning
// S_IDLE   | no credit, waiting for the first accepted coin
// S_ACTIVE | credit held, coins and selections served, timer running
// S_RETURN | paying out change, largest coin first, inputs ignored
module vending_controller #(
  parameter int kNumCoins  = 3,
  parameter int kNumItems  = 4,
  parameter int kTotalBits = 31,
  parameter int kWaitTime  = 100,
  parameter int kTimerBits = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  output logic [kNumItems-1:0]  o_available_item,
  output logic [kNumItems-1:0]  o_output_item,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic [kTotalBits-1:0] o_current_total,
  output logic                  o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RETURN} state_t;

  // Coin values must stay in ascending order: change selection relies on it.
  localparam logic [kTotalBits-1:0] kCoinValue [kNumCoins] =
    '{kTotalBits'(100), kTotalBits'(500), kTotalBits'(1000)};
  localparam logic [kTotalBits-1:0] kItemPrice [kNumItems] =
    '{kTotalBits'(400), kTotalBits'(500), kTotalBits'(1000), kTotalBits'(2000)};
  localparam logic [kTimerBits-1:0] kTimerLoad = kTimerBits'(kWaitTime);

  state_t                state_q, state_d;
  logic [kTotalBits-1:0] total_q, total_d;
  logic [kTimerBits-1:0] timer_q, timer_d;
  logic [kNumItems-1:0]  item_q, item_d;

  logic [kTotalBits:0]   coin_sum, add_sum;
  logic                  accept;
  logic [kNumItems-1:0]  req, serve_onehot;
  logic                  serve;
  logic [kTotalBits-1:0] price;
  logic [kNumCoins-1:0]  ret_coin;
  logic [kTotalBits-1:0] ret_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      total_q <= '0;
      timer_q <= kTimerLoad;
      item_q  <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      timer_q <= timer_d;
      item_q  <= item_d;
    end
  end

  // Sum is one bit wider than the total so overflow shows up as the carry.
  always_comb begin
    coin_sum = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_input_coin[i]) coin_sum = coin_sum + {1'b0, kCoinValue[i]};
    end
    add_sum = {1'b0, total_q} + coin_sum;
    accept  = (coin_sum != '0) && !add_sum[kTotalBits] && (state_q != S_RETURN);
  end

  always_comb begin
    req          = i_select_item & o_available_item;
    serve_onehot = req & (~req + kNumItems'(1));
    serve        = (state_q == S_ACTIVE) && !i_trigger_return && (req != '0);
    price        = '0;
    for (int i = 0; i < kNumItems; i++) begin
      if (serve_onehot[i]) price = kItemPrice[i];
    end
  end

  always_comb begin
    logic [kTotalBits-1:0] next_total;
    next_total = '0;
    state_d    = state_q;
    total_d    = total_q;
    timer_d    = timer_q;
    item_d     = '0;
    case (state_q)
      S_IDLE: begin
        timer_d = kTimerLoad;
        if (accept) begin
          total_d = add_sum[kTotalBits-1:0];
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        next_total = accept ? add_sum[kTotalBits-1:0] : total_q;
        if (serve) begin
          next_total = next_total - price;
          item_d     = serve_onehot;
        end
        total_d = next_total;
        if (i_trigger_return) begin
          state_d = S_RETURN;
        end else if (serve && next_total == '0) begin
          state_d = S_IDLE;
          timer_d = kTimerLoad;
        end else if (accept || serve) begin
          timer_d = kTimerLoad;
        end else if (timer_q == '0) begin
          state_d = S_RETURN;
        end else begin
          timer_d = timer_q - kTimerBits'(1);
        end
      end
      S_RETURN: begin
        timer_d = kTimerLoad;
        // A remainder below the smallest coin cannot be paid and is dropped.
        if (total_q < kCoinValue[0]) begin
          total_d = '0;
          state_d = S_IDLE;
        end else begin
          next_total = total_q - ret_value;
          total_d    = next_total;
          if (next_total == '0) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        total_d = '0;
        timer_d = kTimerLoad;
      end
    endcase
  end

  always_comb begin
    ret_coin  = '0;
    ret_value = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (total_q >= kCoinValue[i]) begin
        ret_coin    = '0;
        ret_coin[i] = 1'b1;
        ret_value   = kCoinValue[i];
      end
    end
    for (int i = 0; i < kNumItems; i++) begin
      o_available_item[i] = (state_q != S_RETURN) && (total_q >= kItemPrice[i]);
    end
    o_return_coin   = (state_q == S_RETURN) ? ret_coin : '0;
    o_busy          = (state_q == S_RETURN);
    o_output_item   = item_q;
    o_current_total = total_q;
  end

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboarded bench for vending_controller: directed scenarios then randomized
// bursts, checked against a queue/integer reference model of the machine rules.
module tb_vending_controller;
  // Narrow total so the overflow-reject path is reachable in a short run.
  localparam int kTB = 12;
  localparam int kW  = 100;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [2:0]      i_input_coin = '0;
  logic [3:0]      i_select_item = '0;
  logic            i_trigger_return = 1'b0;
  logic [3:0]      o_available_item;
  logic [3:0]      o_output_item;
  logic [2:0]      o_return_coin;
  logic [kTB-1:0]  o_current_total;
  logic            o_busy;

  always #5 clk = ~clk;

  vending_controller #(.kTotalBits(kTB), .kWaitTime(kW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_input_coin(i_input_coin),
    .i_select_item(i_select_item),
    .i_trigger_return(i_trigger_return),
    .o_available_item(o_available_item),
    .o_output_item(o_output_item),
    .o_return_coin(o_return_coin),
    .o_current_total(o_current_total),
    .o_busy(o_busy)
  );

  typedef struct {
    int total;
    int avail;
    int item;
    int coin;
    int busy;
  } exp_t;

  exp_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;

  int coin_val [3] = '{100, 500, 1000};
  int price    [4] = '{400, 500, 1000, 2000};
  int max_total = (1 << kTB) - 1;

  // Reference model: mode 0 idle, 1 active, 2 paying change.
  int m_total = 0;
  int m_mode = 0;
  int m_quiet = 0;
  int m_item = 0;
  int changeq[$];

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void build_change(int t);
    int v;
    changeq.delete();
    while (t >= 100) begin
      v = (t >= 1000) ? 1000 : (t >= 500) ? 500 : 100;
      changeq.push_back(v);
      t -= v;
    end
    if (t > 0 || changeq.size() == 0) changeq.push_back(0);
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e.total = m_total;
    e.busy  = (m_mode == 2) ? 1 : 0;
    e.item  = m_item;
    e.avail = 0;
    for (int i = 0; i < 4; i++)
      if (m_mode != 2 && m_total >= price[i]) e.avail |= (1 << i);
    e.coin = 0;
    if (m_mode == 2) begin
      if (changeq[0] == 1000) e.coin = 4;
      else if (changeq[0] == 500) e.coin = 2;
      else if (changeq[0] == 100) e.coin = 1;
    end
    return e;
  endfunction

  task automatic model_step(logic [2:0] c, logic [3:0] s, logic t);
    int csum;
    bit accept;
    int nt;
    int served;
    int v;
    csum = 0;
    served = -1;
    for (int i = 0; i < 3; i++) if (c[i]) csum += coin_val[i];
    accept = (csum > 0) && (m_total + csum <= max_total);
    m_item = 0;
    case (m_mode)
      0: if (accept) begin
        m_total += csum;
        m_mode = 1;
        m_quiet = 0;
      end
      1: begin
        nt = m_total + (accept ? csum : 0);
        if (!t) for (int i = 3; i >= 0; i--) if (s[i] && m_total >= price[i]) served = i;
        if (served >= 0) begin
          nt -= price[served];
          m_item = 1 << served;
        end
        m_total = nt;
        if (accept || served >= 0) m_quiet = 0;
        else m_quiet++;
        if (t) begin
          m_mode = 2;
          build_change(nt);
        end else if (served >= 0 && nt == 0) begin
          m_mode = 0;
        end else if (m_quiet == kW + 1) begin
          m_mode = 2;
          build_change(nt);
        end
      end
      default: begin
        v = changeq.pop_front();
        m_total = (v == 0) ? 0 : m_total - v;
        if (changeq.size() == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic cycle(logic [2:0] c, logic [3:0] s, logic t);
    i_input_coin = c;
    i_select_item = s;
    i_trigger_return = t;
    expq.push_back(model_outputs());
    model_step(c, s, t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle(3'b000, 4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_input_coin = '0;
    i_select_item = '0;
    i_trigger_return = 1'b0;
    m_total = 0;
    m_mode = 0;
    m_quiet = 0;
    m_item = 0;
    changeq.delete();
    expq.push_back(model_outputs());
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("total", int'(o_current_total), e.total);
        check("available", int'(o_available_item), e.avail);
        check("output_item", int'(o_output_item), e.item);
        check("return_coin", int'(o_return_coin), e.coin);
        check("busy", int'(o_busy), e.busy);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    int pct;
    int dens [4] = '{0, 5, 30, 70};
    logic [2:0] c;
    logic [3:0] s;
    logic t;

    @(posedge clk);
    #1;
    do_reset();

    // Availability and single dispense
    cycle(3'b100, 4'b0000, 1'b0);
    cycle(3'b010, 4'b0000, 1'b0);
    cycle(3'b000, 4'b0100, 1'b0);
    idle(2);
    // Coin plus multi-select in one cycle: 500 + 1000 - 400
    cycle(3'b100, 4'b1011, 1'b0);
    idle(1);
    // Build 1700 and pay it out; coins during payout are ignored
    cycle(3'b010, 4'b0000, 1'b0);
    cycle(3'b001, 4'b0000, 1'b0);
    cycle(3'b000, 4'b0000, 1'b1);
    cycle(3'b100, 4'b0000, 1'b0);
    cycle(3'b011, 4'b0000, 1'b0);
    idle(3);
    cycle(3'b000, 4'b0000, 1'b1);
    idle(2);
    // Timeout, then timeout with a reload coin at cycle 50
    cycle(3'b001, 4'b0000, 1'b0);
    idle(kW + 6);
    cycle(3'b001, 4'b0000, 1'b0);
    idle(49);
    cycle(3'b001, 4'b0000, 1'b0);
    idle(kW + 6);
    // Trigger beats select in the same cycle
    cycle(3'b010, 4'b0000, 1'b0);
    cycle(3'b000, 4'b0011, 1'b1);
    idle(3);
    // Asynchronous reset with 1200 outstanding in RETURN
    cycle(3'b101, 4'b0000, 1'b0);
    cycle(3'b001, 4'b0000, 1'b0);
    cycle(3'b000, 4'b0000, 1'b1);
    do_reset();
    idle(2);
    // Overflow rejection near the top of the total range, then dispense to zero
    for (int k = 0; k < 4; k++) cycle(3'b100, 4'b0000, 1'b0);
    cycle(3'b100, 4'b0000, 1'b0);
    cycle(3'b001, 4'b0000, 1'b0);
    cycle(3'b000, 4'b1000, 1'b0);
    cycle(3'b000, 4'b1000, 1'b0);
    idle(3);

    for (int b = 0; b < 40; b++) begin
      len = $urandom_range(10, 160);
      pct = dens[$urandom_range(0, 3)];
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 999) == 0) begin
          do_reset();
        end else begin
          c = ($urandom_range(0, 99) < pct) ? 3'($urandom_range(1, 7)) : 3'b000;
          s = ($urandom_range(0, 99) < pct) ? 4'($urandom_range(1, 15)) : 4'b0000;
          t = ($urandom_range(0, 199) == 0);
          cycle(c, s, t);
        end
      end
    end

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
